// File: rtl/ras_pkg.sv
// Shared constants, operation encoding and pointer-width helper for the
// return address stack.
// Optional feature macro: RAS_REGION_CHECK_EN (adds region_miss_o).
package ras_pkg;

    localparam int RAS_DEPTH_DEFAULT = 8;
    localparam int ADDR_W_DEFAULT    = 32;
    // Number of upper address bits that define a jump "region".
    localparam int REGION_BITS       = 4;

    // One decoded operation per clock; flush outranks everything else.
    typedef enum logic [2:0] {
        OP_NONE      = 3'd0,
        OP_PUSH      = 3'd1,
        OP_POP       = 3'd2,
        OP_REPLACE   = 3'd3,
        OP_UNDERFLOW = 3'd4,
        OP_FLUSH     = 3'd5
    } ras_op_e;

    // Width of a pointer that indexes DEPTH entries (at least 1 bit).
    function automatic int ras_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ras_ptr_ctrl.sv
// Pointer, occupancy count and status-flag control for the return address
// stack. Decodes push/pop/flush into a single operation and exposes it so
// the storage side can act on the same decision.
// ptr_o is the next free slot; the top entry lives at ptr_o-1.
module ras_ptr_ctrl
    import ras_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH_DEFAULT
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  logic                          flush_i,
    output ras_op_e                       op_o,
    output logic [ras_ptr_w(DEPTH)-1:0]   ptr_o,
    output logic [ras_ptr_w(DEPTH):0]     count_o,
    output logic                          overflow_o,
    output logic                          underflow_o
);

    localparam int PTR_W = ras_ptr_w(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    ras_op_e            op;
    logic               empty;
    logic               full;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;

    // Decode the requested operation; a pop paired with a push on an empty
    // stack degenerates to a plain push, so it can never underflow.
    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == CNT_FULL);
        op    = OP_NONE;
        if (flush_i) begin
            op = OP_FLUSH;
        end else if (push_i && pop_i && !empty) begin
            op = OP_REPLACE;
        end else if (push_i) begin
            op = OP_PUSH;
        end else if (pop_i && !empty) begin
            op = OP_POP;
        end else if (pop_i) begin
            op = OP_UNDERFLOW;
        end
    end

    // Next pointer/count/flag values; pointer arithmetic wraps modulo DEPTH
    // so a push while full overwrites the oldest entry.
    always_comb begin
        ptr_d       = ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = 1'b0;
        case (op)
            OP_PUSH: begin
                ptr_d = ptr_q + PTR_W'(1);
                if (full) begin
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + (PTR_W+1)'(1);
                end
            end
            OP_POP: begin
                ptr_d   = ptr_q - PTR_W'(1);
                count_d = count_q - (PTR_W+1)'(1);
            end
            OP_UNDERFLOW: begin
                underflow_d = 1'b1;
            end
            OP_FLUSH: begin
                ptr_d      = '0;
                count_d    = '0;
                overflow_d = 1'b0;
            end
            default: begin
                ptr_d = ptr_q;
            end
        endcase
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign op_o        = op;
    assign ptr_o       = ptr_q;
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule

// File: rtl/return_addr_stack.sv
// Return address stack: calls push PC+4, returns pop it. Storage and the
// registered top-of-stack mux live here; pointer/count/flags come from
// ras_ptr_ctrl.
// Optional feature macro: RAS_REGION_CHECK_EN adds region_miss_o, flagging a
// mismatch between the upper address bits of top_o and pc_i.
module return_addr_stack
    import ras_pkg::*;
#(
    parameter int DEPTH  = RAS_DEPTH_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic                        flush_i,
    input  logic [ADDR_W-1:0]           pc_i,
    output logic [ADDR_W-1:0]           top_o,
    output logic                        valid_o,
    output logic [$clog2(DEPTH):0]      count_o,
    output logic                        overflow_o,
    output logic                        underflow_o
`ifdef RAS_REGION_CHECK_EN
    ,
    output logic                        region_miss_o
`endif
);

    localparam int PTR_W = ras_ptr_w(DEPTH);

    ras_op_e            op;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_m1;
    logic [PTR_W-1:0]   ptr_m2;
    logic [PTR_W:0]     count;
    logic [ADDR_W-1:0]  push_val;
    logic               wr_en;
    logic [PTR_W-1:0]   wr_idx;
    logic [ADDR_W-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0]  top_q, top_d;

    ras_ptr_ctrl #(
        .DEPTH (DEPTH)
    ) u_ptr_ctrl (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push_i),
        .pop_i       (pop_i),
        .flush_i     (flush_i),
        .op_o        (op),
        .ptr_o       (ptr),
        .count_o     (count),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o)
    );

    // Write port and next top value. A replace overwrites the current top
    // slot; a pop exposes the entry below, or 0 when the stack drains.
    always_comb begin
        push_val = pc_i + ADDR_W'(4);
        ptr_m1   = ptr - PTR_W'(1);
        ptr_m2   = ptr_m1 - PTR_W'(1);
        wr_en    = (op == OP_PUSH) || (op == OP_REPLACE);
        wr_idx   = (op == OP_REPLACE) ? ptr_m1 : ptr;
        top_d    = top_q;
        case (op)
            OP_PUSH, OP_REPLACE: top_d = push_val;
            OP_POP:              top_d = (count == (PTR_W+1)'(1)) ? '0 : mem_q[ptr_m2];
            OP_FLUSH:            top_d = '0;
            default:             top_d = top_q;
        endcase
    end

    // Stack storage; contents are unobservable while empty, so no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_idx] <= push_val;
        end
    end

    // Registered top-of-stack, cleared immediately on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            top_q <= '0;
        end else begin
            top_q <= top_d;
        end
    end

    assign top_o   = top_q;
    assign valid_o = (count != '0);
    assign count_o = count;

`ifdef RAS_REGION_CHECK_EN
    // Predicted return target lies in a different upper-address region.
    assign region_miss_o = valid_o &&
        (top_q[ADDR_W-1 -: REGION_BITS] != pc_i[ADDR_W-1 -: REGION_BITS]);
`endif

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed and random checks of return_addr_stack against a queue-based
// reference stack (oldest entry dropped on overflow).
module tb_return_addr_stack;

  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int CW    = 4;
  localparam int EW    = AW + CW + 3;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          push_i;
  logic          pop_i;
  logic          flush_i;
  logic [AW-1:0] pc_i;
  logic [AW-1:0] top_o;
  logic          valid_o;
  logic [CW-1:0] count_o;
  logic          overflow_o;
  logic          underflow_o;
`ifdef RAS_REGION_CHECK_EN
  logic          region_miss_o;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  logic [EW-1:0] exp_q[$];
  logic [AW-1:0] m_stk[$];
  logic          m_ovf;
  logic          m_unf;

  return_addr_stack #(
    .DEPTH  (DEPTH),
    .ADDR_W (AW)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push_i),
    .pop_i       (pop_i),
    .flush_i     (flush_i),
    .pc_i        (pc_i),
    .top_o       (top_o),
    .valid_o     (valid_o),
    .count_o     (count_o),
    .overflow_o  (overflow_o),
    .underflow_o (underflow_o)
`ifdef RAS_REGION_CHECK_EN
    ,
    .region_miss_o (region_miss_o)
`endif
  );

  // clock
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference model update; pushes the expected post-edge outputs
  task automatic model_apply(input logic p, input logic q, input logic f, input logic [AW-1:0] pcv);
    logic [AW-1:0] v;
    logic [AW-1:0] t;
    v = pcv + 32'd4;
    m_unf = 1'b0;
    if (f) begin
      m_stk.delete();
      m_ovf = 1'b0;
    end else if (p && q && m_stk.size() > 0) begin
      m_stk[m_stk.size()-1] = v;
    end else if (p) begin
      if (m_stk.size() == DEPTH) begin
        void'(m_stk.pop_front());
        m_ovf = 1'b1;
      end
      m_stk.push_back(v);
    end else if (q) begin
      if (m_stk.size() > 0) void'(m_stk.pop_back());
      else m_unf = 1'b1;
    end
    t = (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : '0;
    exp_q.push_back({t, CW'(m_stk.size()), (m_stk.size() > 0), m_ovf, m_unf});
  endtask

  // drive one operation for one clock, then score the outputs
  task automatic step(input logic p, input logic q, input logic f, input logic [AW-1:0] pcv);
    logic [EW-1:0] e;
    @(negedge clk_i);
    push_i = p; pop_i = q; flush_i = f; pc_i = pcv;
    model_apply(p, q, f, pcv);
    @(posedge clk_i);
    #1;
    e = exp_q.pop_front();
    check("sb_top",   top_o,       e[EW-1 -: AW]);
    check("sb_count", AW'(count_o), AW'(e[6:3]));
    check("sb_valid", AW'(valid_o), AW'(e[2]));
    check("sb_ovf",   AW'(overflow_o), AW'(e[1]));
    check("sb_unf",   AW'(underflow_o), AW'(e[0]));
    push_i = 1'b0; pop_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_top"},   top_o, '0);
    check({tag, "_count"}, AW'(count_o), '0);
    check({tag, "_valid"}, AW'(valid_o), '0);
    check({tag, "_ovf"},   AW'(overflow_o), '0);
    check({tag, "_unf"},   AW'(underflow_o), '0);
  endtask

  initial begin
    rst_i = 1'b1; push_i = 1'b0; pop_i = 1'b0; flush_i = 1'b0; pc_i = '0;
    m_ovf = 1'b0; m_unf = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_zero("reset");
    @(negedge clk_i);
    rst_i = 1'b0;

    // first call
    step(1, 0, 0, 32'h0040_0010);
    check("first_top", top_o, 32'h0040_0014);
    check("first_count", AW'(count_o), 32'd1);
    check("first_valid", AW'(valid_o), 32'd1);

    // three calls, two returns
    step(0, 0, 1, '0);
    step(1, 0, 0, 32'h100);
    step(1, 0, 0, 32'h200);
    step(1, 0, 0, 32'h300);
    check("lifo_top3", top_o, 32'h304);
    check("lifo_cnt3", AW'(count_o), 32'd3);
    step(0, 1, 0, '0);
    check("lifo_top2", top_o, 32'h204);
    check("lifo_cnt2", AW'(count_o), 32'd2);
    step(0, 1, 0, '0);
    check("lifo_top1", top_o, 32'h104);
    check("lifo_cnt1", AW'(count_o), 32'd1);

    // overflow by one, drain, then underflow
    step(0, 0, 1, '0);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 32'(4 * i));
    check("ovf_count", AW'(count_o), 32'd8);
    check("ovf_flag", AW'(overflow_o), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check("drain_top", top_o, 32'h24 - 32'(4 * i));
      step(0, 1, 0, '0);
    end
    check("drained_count", AW'(count_o), 32'd0);
    check("drained_top", top_o, 32'd0);
    step(0, 1, 0, '0);
    check("unf_pulse", AW'(underflow_o), 32'd1);
    step(0, 0, 0, '0);
    check("unf_clear", AW'(underflow_o), 32'd0);

    // simultaneous push/pop and address wrap
    step(0, 0, 1, '0);
    step(1, 0, 0, 32'h1000);
    check("repl_pre", top_o, 32'h1004);
    step(1, 1, 0, 32'h2000);
    check("repl_top", top_o, 32'h2004);
    check("repl_cnt", AW'(count_o), 32'd1);
    step(1, 0, 0, 32'hFFFF_FFFC);
    check("wrap_top", top_o, 32'h0);
    check("wrap_valid", AW'(valid_o), 32'd1);
    check("wrap_cnt", AW'(count_o), 32'd2);
    // push+pop on an empty stack acts as a push
    step(0, 0, 1, '0);
    step(1, 1, 0, 32'h3000);
    check("pp_empty_top", top_o, 32'h3004);
    check("pp_empty_unf", AW'(underflow_o), 32'd0);

    // flush beats push with 3 entries and overflow set
    step(0, 0, 1, '0);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 32'h800 + 32'(16 * i));
    for (int i = 0; i < 5; i++) step(0, 1, 0, '0);
    check("pre_flush_cnt", AW'(count_o), 32'd3);
    check("pre_flush_ovf", AW'(overflow_o), 32'd1);
    step(1, 0, 1, 32'h500);
    check_zero("flush");

    // random traffic
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0), $urandom());

    // asynchronous reset between edges, with a push in flight
    step(0, 0, 1, '0);
    step(1, 0, 0, 32'h40);
    step(1, 0, 0, 32'h80);
    check("pre_rst_cnt", AW'(count_o), 32'd2);
    @(posedge clk_i);
    #3;
    push_i = 1'b1; pc_i = 32'h900;
    rst_i = 1'b1;
    #1;
    check_zero("async_rst");
    @(posedge clk_i);
    #1;
    check_zero("rst_hold");
    @(negedge clk_i);
    rst_i = 1'b0; push_i = 1'b0;
    m_stk.delete(); m_ovf = 1'b0;
    step(0, 0, 0, '0);
    check("post_rst_cnt", AW'(count_o), 32'd0);

`ifdef RAS_REGION_CHECK_EN
    step(1, 0, 0, 32'h1000_0000);
    check("region_top", top_o, 32'h1000_0004);
    @(negedge clk_i);
    pc_i = 32'h2000_0000;
    #1;
    check("region_miss", AW'(region_miss_o), 32'd1);
    pc_i = 32'h1000_0020;
    #1;
    check("region_hit", AW'(region_miss_o), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/return_addr_stack.md
RETURN_ADDR_STACK -- requirements
Module: return_addr_stack

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the number of stack entries (power of two, 2..64).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the address width.
REQ-003 SHALL have clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_i, input, 1, asynchronous active-high reset.
REQ-005 SHALL have push_i, input, 1, a call retiring (JAL/JALR); pushes the return address.
REQ-006 SHALL have pop_i, input, 1, a return retiring (JR $ra); pops the top entry.
REQ-007 SHALL have flush_i, input, 1, pipeline flush; empties the stack.
REQ-008 SHALL have pc_i, input, ADDR_W, PC of the instruction asserting push_i.
REQ-009 SHALL have top_o, output, ADDR_W, the current top entry (registered).
REQ-010 SHALL have valid_o, output, 1, high when the stack holds at least one entry.
REQ-011 SHALL have count_o, output, $clog2(DEPTH)+1, the number of valid entries.
REQ-012 SHALL have overflow_o, output, 1, sticky: a push occurred while full.
REQ-013 SHALL have underflow_o, output, 1, one-cycle pulse: a pop occurred while empty.

Function
REQ-014 SHALL compute the pushed value as pc_i+4 modulo 2^ADDR_W (0xFFFFFFFC wraps to 0x00000000).
REQ-015 SHALL take effect one cycle after the push/pop edge; top_o, valid_o and count_o reflect the new state in the following cycle.
REQ-016 SHALL implement push alone as follows: write to the next slot, advance the top pointer, and increment count.
REQ-017 SHALL implement pop alone when not empty as follows: retreat the top pointer and decrement count; top_o shows the previous entry.
REQ-018 SHALL, on pop while empty: leave state unchanged, keep top_o at 0, and pulse underflow_o for exactly one cycle.
REQ-019 SHALL, on push while full: overwrite the oldest entry circularly, keep count at DEPTH, and set overflow_o until reset or flush.
REQ-020 SHALL, on simultaneous push and pop: replace the top entry with pc_i+4, leave count unchanged, and never underflow; if empty, treat it as push.
REQ-021 SHALL give flush_i priority over push_i and pop_i: next cycle count=0, valid_o=0, top_o=0, overflow_o=0.
REQ-022 SHALL drive top_o to 0 whenever valid_o is 0.
REQ-023 SHALL wrap pointer arithmetic modulo DEPTH; count saturates at DEPTH and never goes below 0.

Reset
REQ-024 SHALL, on rst_i high, immediately clear pointer, count, top_o, overflow_o and underflow_o to 0, independent of clk_i.
REQ-025 SHALL discard any operation on the same edge when rst_i is asserted mid-operation; after release, the stack is empty.
REQ-026 SHALL NOT require stack storage entries to be reset; they are unobservable while count is 0.

Configuration
REQ-027 SHALL, when RAS_REGION_CHECK_EN is defined, add output region_miss_o (1 bit): high when valid_o is 1 and top_o[ADDR_W-1:ADDR_W-4] differs from pc_i[ADDR_W-1:ADDR_W-4] (jump region mismatch); reset value 0.
REQ-028 SHALL, when RAS_REGION_CHECK_EN is undefined, omit region_miss_o entirely, with no port and no logic.

Structure
REQ-029 SHALL place RAS_DEPTH_DEFAULT, ADDR_W_DEFAULT, the REGION_BITS=4 constant and the pointer-width function in shared package ras_pkg.
REQ-030 SHALL contain one sub-module, ras_ptr_ctrl (pointer/count/flag update logic), with storage and output muxing in the top module.

Verification
REQ-031 SHALL cover: reset, then push pc=0x00400010 -> next cycle top_o=0x00400014, valid_o=1, count_o=1.
REQ-032 SHALL cover: push 0x100, 0x200, 0x300, then pop twice -> top_o sequence 0x304, 0x204, 0x104; count_o 3, 2, 1.
REQ-033 SHALL cover: DEPTH=8, push 9 times (pc=0x0..0x20 step 4) -> count_o=8, overflow_o=1; 8 pops return 0x24 down to 0x8, then a 9th pop pulses underflow_o for 1 cycle.
REQ-034 SHALL cover: top=0x1004, simultaneous push pc=0x2000 and pop -> top_o=0x2004, count unchanged; push pc=0xFFFFFFFC -> top_o=0x00000000.
REQ-035 SHALL cover: 3 entries, flush_i together with push_i -> count_o=0, valid_o=0, top_o=0, overflow_o cleared.
REQ-036 SHALL cover: rst_i asserted between clock edges with 2 entries -> outputs 0 immediately; with RAS_REGION_CHECK_EN, top_o=0x10000004 and pc_i=0x20000000 -> region_miss_o=1.
